vga_console_writer: RTL



---
 rtl/vga_console_writer_if.sv | 27 ++
 rtl/vga_console_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_console_writer_if.sv
// Character stream, char-RAM ports and cursor/status of the console writer.
// master = the writer itself; slave = character source plus char RAM.
interface vga_console_writer_if;
  logic        ch_valid;
  logic [6:0]  ch_data;
  logic        ch_ready;
  logic        vram_we;
  logic [12:0] vram_wa;
  logic [6:0]  vram_wd;
  logic [12:0] vram_ra;
  logic [6:0]  vram_rd;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  modport master (
    input  ch_valid, ch_data, vram_rd,
    output ch_ready, vram_we, vram_wa, vram_wd, vram_ra,
           cursor_row, cursor_col, busy
  );

  modport slave (
    output ch_valid, ch_data, vram_rd,
    input  ch_ready, vram_we, vram_wa, vram_wd, vram_ra,
           cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/vga_console_writer.sv
// Text-console writer: ASCII stream -> 80x60 char-RAM writes with cursor,
// CR/LF/BS/FF handling, full clear and one-row scroll through the read port.
module vga_console_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 60,
  parameter logic [6:0]  BLANK = 7'h20
) (
  input  logic                 sys_clk,
  input  logic                 clrn,
  vga_console_writer_if.master bus
);

  localparam logic [12:0] COLS13    = 13'(COLS);
  localparam logic [12:0] LAST      = 13'(COLS*ROWS - 1);
  localparam logic [12:0] COPY_LAST = 13'((ROWS-1)*COLS - 1);
  localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_COPY, SCROLL_CLEAR} state_t;

  state_t      state_q, state_d;
  logic [12:0] counter_q, counter_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [12:0] wa_q, wa_d;
  logic [6:0]  wd_q, wd_d;
  logic [12:0] cur_addr;
  logic        adv;

  assign cur_addr = {7'd0, row_q} * COLS13 + {6'd0, col_q};

  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= CLEAR;
      counter_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      row_q     <= row_d;
      col_q     <= col_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    adv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ch_valid) begin
          if (bus.ch_data >= 7'h20 && bus.ch_data <= 7'h7E) begin
            we_d = 1'b1;
            wa_d = cur_addr;
            wd_d = bus.ch_data;
            if (col_q == COL_MAX) begin
              col_d = '0;
              adv   = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (bus.ch_data == 7'h0D) begin
            col_d = '0;
          end else if (bus.ch_data == 7'h0A) begin
            col_d = '0;
            adv   = 1'b1;
          end else if (bus.ch_data == 7'h08) begin
            // row*COLS+col-1 is the blanked cell in both the same-row and wrap cases
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
              we_d  = 1'b1;
              wa_d  = cur_addr - 13'd1;
              wd_d  = BLANK;
            end else if (row_q != 6'd0) begin
              row_d = row_q - 6'd1;
              col_d = COL_MAX;
              we_d  = 1'b1;
              wa_d  = cur_addr - 13'd1;
              wd_d  = BLANK;
            end
          end else if (bus.ch_data == 7'h0C) begin
            row_d     = '0;
            col_d     = '0;
            counter_d = '0;
            state_d   = CLEAR;
          end
          if (adv) begin
            if (row_q != ROW_MAX) begin
              row_d = row_q + 6'd1;
            end else begin
              col_d     = '0;
              counter_d = '0;
              state_d   = SCROLL_COPY;
            end
          end
        end
      end
      CLEAR: begin
        we_d = 1'b1;
        wa_d = counter_q;
        wd_d = BLANK;
        if (counter_q == LAST) begin
          counter_d = '0;
          state_d   = IDLE;
        end else begin
          counter_d = counter_q + 13'd1;
        end
      end
      SCROLL_COPY: begin
        // read runs one row ahead of the write, so sources are never overwritten first
        we_d      = 1'b1;
        wa_d      = counter_q;
        wd_d      = bus.vram_rd;
        counter_d = counter_q + 13'd1;
        if (counter_q == COPY_LAST) state_d = SCROLL_CLEAR;
      end
      SCROLL_CLEAR: begin
        we_d = 1'b1;
        wa_d = counter_q;
        wd_d = BLANK;
        if (counter_q == LAST) begin
          counter_d = '0;
          state_d   = IDLE;
        end else begin
          counter_d = counter_q + 13'd1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign bus.ch_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.vram_we    = we_q;
  assign bus.vram_wa    = wa_q;
  assign bus.vram_wd    = wd_q;
  assign bus.vram_ra    = (state_q == SCROLL_COPY) ? counter_q + COLS13 : 13'd0;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;

endmodule
